uart_frame_tx: RTL and testbench

//  Parametrised UART frame transmitter: latches N_NUMS signed words of NUM_WIDTH bits.

---
 rtl/uart_frame_tx_if.sv | 27 ++
 rtl/uart_frame_tx.sv | 176 +++++++++++++++++
 tb/tb_uart_frame_tx.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_tx_if.sv
// Request/serial-line bundle for uart_frame_tx: the requester drives the frame words
// and send_data, the transmitter returns the line, its readiness and progress.
interface uart_frame_tx_if #(
    parameter int N_NUMS    = 6,
    parameter int NUM_WIDTH = 16
);
    localparam int BIDX_W = $clog2(N_NUMS * NUM_WIDTH / 8 + 1);

    // Handshake: a frame is accepted on a clk edge where tx_ready=1 and send_data=1;
    // send_data while tx_ready=0 is dropped, and tx_nums is only needed on that edge.
    logic                                 send_data;
    logic [N_NUMS-1:0][NUM_WIDTH-1:0]     tx_nums;
    logic                                 tx;
    logic                                 tx_ready;
    logic                                 frame_done;
    logic [BIDX_W-1:0]                    byte_index;

    modport master (
        output send_data, tx_nums,
        input  tx, tx_ready, frame_done, byte_index
    );

    modport slave (
        input  send_data, tx_nums,
        output tx, tx_ready, frame_done, byte_index
    );
endinterface

// File: rtl/uart_frame_tx.sv
// Frame transmitter: snapshots N_NUMS words and sends them byte by byte as 8-bit
// UART characters with optional parity and one or two stop bits.
module uart_frame_tx #(
    parameter int N_NUMS          = 6,
    parameter int NUM_WIDTH       = 16,
    parameter int CLKS_PER_BIT    = 434,
    parameter int PARITY          = 0,
    parameter int STOP_BITS       = 1,
    parameter int MSB_FIRST_BYTES = 1
) (
    input  logic             clk,
    input  logic             reset,
    uart_frame_tx_if.slave   bus,
    output logic [2:0]       dbg_state_o
);
    localparam int BPW     = NUM_WIDTH / 8;
    localparam int NBYTES  = N_NUMS * BPW;
    localparam int BIDX_W  = $clog2(NBYTES + 1);
    localparam int TIMER_W = $clog2(CLKS_PER_BIT);
    localparam int FLAT_W  = N_NUMS * NUM_WIDTH;

    if (NUM_WIDTH % 8 != 0 || NUM_WIDTH < 8) begin : g_bad_width
        $error("uart_frame_tx: NUM_WIDTH must be a positive multiple of 8");
    end
    if (N_NUMS < 1 || CLKS_PER_BIT < 2) begin : g_bad_size
        $error("uart_frame_tx: N_NUMS must be >=1 and CLKS_PER_BIT >=2");
    end
    if (PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_fmt
        $error("uart_frame_tx: PARITY must be 0..2 and STOP_BITS 1 or 2");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_e;

    state_e               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [2:0]           bit_q, bit_d;
    logic                 stop2_q, stop2_d;
    logic [BIDX_W-1:0]    byte_q, byte_d;
    logic                 tx_q, tx_d;
    logic                 ready_q, ready_d;
    logic                 done_q, done_d;
    logic [FLAT_W-1:0]    shadow_q;

    logic                 accept;
    logic                 last_tick;
    logic [7:0]           cur_byte;
    logic                 parity_bit;

    // Byte idx of the frame: word idx/BPW, lane chosen by the byte-order parameter.
    function automatic logic [7:0] pick_byte(input logic [FLAT_W-1:0] flat, input int idx);
        int word;
        int lane;
        word = idx / BPW;
        lane = idx % BPW;
        if (MSB_FIRST_BYTES != 0) lane = BPW - 1 - lane;
        return flat[word*NUM_WIDTH + lane*8 +: 8];
    endfunction

    assign accept     = ready_q && bus.send_data;
    assign last_tick  = (timer_q == TIMER_W'(CLKS_PER_BIT - 1));
    assign cur_byte   = pick_byte(shadow_q, int'(byte_q));
    assign parity_bit = (^cur_byte) ^ (PARITY == 2);

    // Snapshot is deliberately left out of reset; it is always rewritten on accept.
    always_ff @(posedge clk) begin
        if (accept) shadow_q <= bus.tx_nums;
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        bit_d   = bit_q;
        stop2_d = stop2_q;
        byte_d  = byte_q;
        tx_d    = tx_q;
        ready_d = ready_q;
        done_d  = 1'b0;

        if (state_q != S_IDLE) timer_d = last_tick ? '0 : timer_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_START;
                    tx_d    = 1'b0;
                    ready_d = 1'b0;
                    timer_d = '0;
                    byte_d  = '0;
                end
            end
            S_START: begin
                if (last_tick) begin
                    state_d = S_DATA;
                    bit_d   = 3'd0;
                    tx_d    = cur_byte[0];
                end
            end
            S_DATA: begin
                if (last_tick) begin
                    if (bit_q == 3'd7) begin
                        if (PARITY != 0) begin
                            state_d = S_PARITY;
                            tx_d    = parity_bit;
                        end else begin
                            state_d = S_STOP;
                            stop2_d = 1'b0;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = cur_byte[bit_q + 3'd1];
                    end
                end
            end
            S_PARITY: begin
                if (last_tick) begin
                    state_d = S_STOP;
                    stop2_d = 1'b0;
                    tx_d    = 1'b1;
                end
            end
            S_STOP: begin
                // Next start bit follows the stop bit directly; only frame end idles.
                if (last_tick) begin
                    if (STOP_BITS == 2 && !stop2_q) begin
                        stop2_d = 1'b1;
                    end else if (byte_q == BIDX_W'(NBYTES - 1)) begin
                        state_d = S_IDLE;
                        byte_d  = '0;
                        ready_d = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_START;
                        byte_d  = byte_q + 1'b1;
                        tx_d    = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            bit_q   <= 3'd0;
            stop2_q <= 1'b0;
            byte_q  <= '0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            bit_q   <= bit_d;
            stop2_q <= stop2_d;
            byte_q  <= byte_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    assign bus.tx         = tx_q;
    assign bus.tx_ready   = ready_q;
    assign bus.frame_done = done_q;
    assign bus.byte_index = byte_q;
    assign dbg_state_o    = state_q;
endmodule

// File: tb/tb_uart_frame_tx.sv
// Bench for uart_frame_tx: four parameterisations share one clock and reset; the
// serial line is captured cycle by cycle and decoded against an expected byte queue.
module tb_uart_frame_tx;
    localparam int CPB = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uart_frame_tx_if #(.N_NUMS(6), .NUM_WIDTH(16)) ifa ();
    uart_frame_tx_if #(.N_NUMS(1), .NUM_WIDTH(16)) ifb ();
    uart_frame_tx_if #(.N_NUMS(1), .NUM_WIDTH(16)) ifc ();
    uart_frame_tx_if #(.N_NUMS(1), .NUM_WIDTH(24)) ifd ();
    logic [2:0] dbg_a, dbg_b, dbg_c, dbg_d;

    uart_frame_tx #(.N_NUMS(6), .NUM_WIDTH(16), .CLKS_PER_BIT(CPB), .PARITY(0),
                    .STOP_BITS(1), .MSB_FIRST_BYTES(1))
        dut_a (.clk(clk), .reset(reset), .bus(ifa), .dbg_state_o(dbg_a));
    uart_frame_tx #(.N_NUMS(1), .NUM_WIDTH(16), .CLKS_PER_BIT(CPB), .PARITY(1),
                    .STOP_BITS(1), .MSB_FIRST_BYTES(1))
        dut_b (.clk(clk), .reset(reset), .bus(ifb), .dbg_state_o(dbg_b));
    uart_frame_tx #(.N_NUMS(1), .NUM_WIDTH(16), .CLKS_PER_BIT(CPB), .PARITY(2),
                    .STOP_BITS(1), .MSB_FIRST_BYTES(1))
        dut_c (.clk(clk), .reset(reset), .bus(ifc), .dbg_state_o(dbg_c));
    uart_frame_tx #(.N_NUMS(1), .NUM_WIDTH(24), .CLKS_PER_BIT(CPB), .PARITY(0),
                    .STOP_BITS(2), .MSB_FIRST_BYTES(0))
        dut_d (.clk(clk), .reset(reset), .bus(ifd), .dbg_state_o(dbg_d));

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q[$];

    logic cap_tx   [0:1023];
    logic cap_done [0:1023];
    logic cap_rdy  [0:1023];
    int   cap_bidx [0:1023];

    logic [15:0] words [6];

    // Sample k is taken mid-cycle k, where cycle 0 starts at the accept edge.
    task automatic capture(input int which, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            case (which)
                0: begin cap_tx[i] = ifa.tx; cap_done[i] = ifa.frame_done;
                         cap_rdy[i] = ifa.tx_ready; cap_bidx[i] = int'(ifa.byte_index); end
                1: begin cap_tx[i] = ifb.tx; cap_done[i] = ifb.frame_done;
                         cap_rdy[i] = ifb.tx_ready; cap_bidx[i] = int'(ifb.byte_index); end
                2: begin cap_tx[i] = ifc.tx; cap_done[i] = ifc.frame_done;
                         cap_rdy[i] = ifc.tx_ready; cap_bidx[i] = int'(ifc.byte_index); end
                default: begin cap_tx[i] = ifd.tx; cap_done[i] = ifd.frame_done;
                         cap_rdy[i] = ifd.tx_ready; cap_bidx[i] = int'(ifd.byte_index); end
            endcase
        end
    endtask

    task automatic set_send(input int which, input logic v);
        case (which)
            0: ifa.send_data = v;
            1: ifb.send_data = v;
            2: ifc.send_data = v;
            default: ifd.send_data = v;
        endcase
    endtask

    task automatic pulse_send(input int which);
        @(negedge clk);
        set_send(which, 1'b1);
        @(posedge clk);
        #1 set_send(which, 1'b0);
    endtask

    // Ideal line level at bit slot pos of one character.
    function automatic logic exp_bit(input logic [7:0] b, input int pos, input int pm);
        if (pos == 0) return 1'b0;
        if (pos <= 8) return b[pos-1];
        if (pos == 9 && pm != 0) return (pm == 1) ? (^b) : ~(^b);
        return 1'b1;
    endfunction

    function automatic int span_errors(input int base, input logic [7:0] b,
                                       input int pm, input int nstop);
        int bpb;
        int bad;
        bpb = 10 + ((pm != 0) ? 1 : 0) + (nstop - 1);
        bad = 0;
        for (int c = 0; c < bpb*CPB; c++)
            if (cap_tx[base + c] !== exp_bit(b, c / CPB, pm)) bad++;
        return bad;
    endfunction

    function automatic logic [7:0] decode(input int base);
        logic [7:0] d;
        for (int i = 0; i < 8; i++) d[i] = cap_tx[base + (i+1)*CPB + CPB/2];
        return d;
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (ifa.tx !== 1'b1 || ifa.tx_ready !== 1'b1 || ifa.frame_done !== 1'b0 ||
            ifa.byte_index !== 4'd0) begin
            n_errors++;
            $display("FAIL reset_hold_a: tx=%b rdy=%b done=%b idx=%0d, want 1 1 0 0",
                     ifa.tx, ifa.tx_ready, ifa.frame_done, ifa.byte_index);
        end
        n_checks++;
        if (ifd.tx !== 1'b1 || ifd.tx_ready !== 1'b1 || ifd.frame_done !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_hold_d: tx=%b rdy=%b done=%b, want 1 1 0",
                     ifd.tx, ifd.tx_ready, ifd.frame_done);
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (ifa.tx !== 1'b1 || ifa.tx_ready !== 1'b1 || ifa.frame_done !== 1'b0 ||
            ifa.byte_index !== 4'd0) begin
            n_errors++;
            $display("FAIL reset_release_a: tx=%b rdy=%b done=%b idx=%0d, want 1 1 0 0",
                     ifa.tx, ifa.tx_ready, ifa.frame_done, ifa.byte_index);
        end
    endtask

    task automatic test_frame();
        logic [7:0] e, got;
        int errs;
        words = '{16'h175B, 16'hF6A5, 16'hFEDA, 16'hFD3C, 16'h00C1, 16'hDABE};
        for (int i = 0; i < 6; i++) begin
            ifa.tx_nums[i] = words[i];
            exp_q.push_back(words[i][15:8]);
            exp_q.push_back(words[i][7:0]);
        end
        pulse_send(0);
        capture(0, 482);
        for (int b = 0; b < 12; b++) begin
            e = exp_q.pop_front();
            got = decode(b*40);
            errs = span_errors(b*40, e, 0, 1);
            n_checks++;
            if (got !== e || errs != 0) begin
                n_errors++;
                $display("FAIL frame_byte%0d: got %h (%0d bad cycles), want %h", b, got, errs, e);
            end
            n_checks++;
            if (cap_bidx[b*40 + 20] != b) begin
                n_errors++;
                $display("FAIL frame_index%0d: got %0d, want %0d", b, cap_bidx[b*40 + 20], b);
            end
        end
        n_checks++;
        if (cap_done[479] !== 1'b0 || cap_rdy[479] !== 1'b0 || cap_done[480] !== 1'b1 ||
            cap_rdy[480] !== 1'b1 || cap_tx[480] !== 1'b1 || cap_done[481] !== 1'b0) begin
            n_errors++;
            $display("FAIL frame_done_timing: done@479..481=%b%b%b rdy@479,480=%b%b, want 010 01",
                     cap_done[479], cap_done[480], cap_done[481], cap_rdy[479], cap_rdy[480]);
        end
    endtask

    task automatic test_parity();
        logic [7:0] e, got;
        int errs;
        logic want_p0, want_p1;
        ifb.tx_nums[0] = 16'h00C1;
        ifc.tx_nums[0] = 16'h00C1;
        for (int pm = 1; pm <= 2; pm++) begin
            exp_q.push_back(8'h00);
            exp_q.push_back(8'hC1);
            pulse_send(pm);
            capture(pm, 90);
            for (int b = 0; b < 2; b++) begin
                e = exp_q.pop_front();
                got = decode(b*44);
                errs = span_errors(b*44, e, pm, 1);
                n_checks++;
                if (got !== e || errs != 0) begin
                    n_errors++;
                    $display("FAIL parity%0d_byte%0d: got %h (%0d bad cycles), want %h",
                             pm, b, got, errs, e);
                end
            end
            want_p0 = (pm == 1) ? 1'b0 : 1'b1;
            want_p1 = (pm == 1) ? 1'b1 : 1'b0;
            n_checks++;
            if (cap_tx[38] !== want_p0 || cap_tx[44 + 38] !== want_p1) begin
                n_errors++;
                $display("FAIL parity%0d_bits: got %b %b, want %b %b",
                         pm, cap_tx[38], cap_tx[82], want_p0, want_p1);
            end
            n_checks++;
            if (cap_done[87] !== 1'b0 || cap_done[88] !== 1'b1 || cap_rdy[88] !== 1'b1) begin
                n_errors++;
                $display("FAIL parity%0d_done: done@87,88=%b%b rdy@88=%b, want 01 1",
                         pm, cap_done[87], cap_done[88], cap_rdy[88]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] e, got;
        logic [15:0] w;
        int errs, ndone;
        for (int i = 0; i < 6; i++) begin
            w = 16'($urandom_range(0, 65535));
            ifa.tx_nums[i] = w;
            exp_q.push_back(w[15:8]);
            exp_q.push_back(w[7:0]);
        end
        pulse_send(0);
        fork
            capture(0, 964);
            begin
                repeat (101) @(negedge clk);
                for (int i = 0; i < 6; i++) begin
                    w = 16'($urandom_range(0, 65535));
                    ifa.tx_nums[i] = w;
                    exp_q.push_back(w[15:8]);
                    exp_q.push_back(w[7:0]);
                end
                ifa.send_data = 1'b1;
                @(negedge clk);
                ifa.send_data = 1'b0;
                repeat (369) @(negedge clk);
                ifa.send_data = 1'b1;
                repeat (16) @(negedge clk);
                ifa.send_data = 1'b0;
            end
        join
        for (int f = 0; f < 2; f++) begin
            for (int b = 0; b < 12; b++) begin
                e = exp_q.pop_front();
                got = decode(f*481 + b*40);
                errs = span_errors(f*481 + b*40, e, 0, 1);
                n_checks++;
                if (got !== e || errs != 0) begin
                    n_errors++;
                    $display("FAIL b2b_frame%0d_byte%0d: got %h (%0d bad cycles), want %h",
                             f, b, got, errs, e);
                end
            end
        end
        n_checks++;
        if (cap_rdy[102] !== 1'b0) begin
            n_errors++;
            $display("FAIL midframe_ready: got %b, want 0", cap_rdy[102]);
        end
        n_checks++;
        if (cap_done[480] !== 1'b1 || cap_tx[480] !== 1'b1 || cap_tx[481] !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_gap: done@480=%b tx@480,481=%b%b, want 1 10",
                     cap_done[480], cap_tx[480], cap_tx[481]);
        end
        ndone = 0;
        for (int i = 0; i < 964; i++) if (cap_done[i] === 1'b1) ndone++;
        n_checks++;
        if (ndone != 2 || cap_done[961] !== 1'b1 || cap_rdy[963] !== 1'b1 || cap_tx[963] !== 1'b1) begin
            n_errors++;
            $display("FAIL b2b_frame_count: pulses=%0d done@961=%b rdy@963=%b, want 2 1 1",
                     ndone, cap_done[961], cap_rdy[963]);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] e, got;
        logic [15:0] w;
        int errs;
        for (int i = 0; i < 6; i++) ifa.tx_nums[i] = words[i];
        pulse_send(0);
        repeat (98) @(negedge clk);
        n_checks++;
        if (ifa.tx !== 1'b0 || ifa.byte_index !== 4'd2) begin
            n_errors++;
            $display("FAIL pre_reset_line: tx=%b idx=%0d, want 0 2", ifa.tx, ifa.byte_index);
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (ifa.tx !== 1'b1 || ifa.tx_ready !== 1'b1 || ifa.frame_done !== 1'b0 ||
            ifa.byte_index !== 4'd0) begin
            n_errors++;
            $display("FAIL async_reset: tx=%b rdy=%b done=%b idx=%0d, want 1 1 0 0",
                     ifa.tx, ifa.tx_ready, ifa.frame_done, ifa.byte_index);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            w = 16'($urandom_range(0, 65535));
            ifa.tx_nums[i] = w;
            exp_q.push_back(w[15:8]);
            exp_q.push_back(w[7:0]);
        end
        pulse_send(0);
        capture(0, 482);
        n_checks++;
        if (cap_bidx[2] != 0 || cap_tx[2] !== 1'b0) begin
            n_errors++;
            $display("FAIL restart_byte0: idx=%0d tx=%b, want 0 0", cap_bidx[2], cap_tx[2]);
        end
        for (int b = 0; b < 12; b++) begin
            e = exp_q.pop_front();
            got = decode(b*40);
            errs = span_errors(b*40, e, 0, 1);
            n_checks++;
            if (got !== e || errs != 0) begin
                n_errors++;
                $display("FAIL restart_byte%0d: got %h (%0d bad cycles), want %h", b, got, errs, e);
            end
        end
        n_checks++;
        if (cap_done[480] !== 1'b1) begin
            n_errors++;
            $display("FAIL restart_done: got %b, want 1", cap_done[480]);
        end
    endtask

    task automatic test_wide_lsb_first();
        logic [7:0] e, got;
        int errs;
        ifd.tx_nums[0] = 24'hABCDEF;
        exp_q.push_back(8'hEF);
        exp_q.push_back(8'hCD);
        exp_q.push_back(8'hAB);
        pulse_send(3);
        capture(3, 134);
        for (int b = 0; b < 3; b++) begin
            e = exp_q.pop_front();
            got = decode(b*44);
            errs = span_errors(b*44, e, 0, 2);
            n_checks++;
            if (got !== e || errs != 0) begin
                n_errors++;
                $display("FAIL wide_byte%0d: got %h (%0d bad cycles), want %h", b, got, errs, e);
            end
        end
        n_checks++;
        if (cap_done[131] !== 1'b0 || cap_done[132] !== 1'b1 || cap_rdy[132] !== 1'b1) begin
            n_errors++;
            $display("FAIL wide_done: done@131,132=%b%b rdy@132=%b, want 01 1",
                     cap_done[131], cap_done[132], cap_rdy[132]);
        end
    endtask

    initial begin
        reset = 1'b0;
        ifa.send_data = 1'b0; ifa.tx_nums = '0;
        ifb.send_data = 1'b0; ifb.tx_nums = '0;
        ifc.send_data = 1'b0; ifc.tx_nums = '0;
        ifd.send_data = 1'b0; ifd.tx_nums = '0;
        test_reset();
        test_frame();
        test_parity();
        test_back_to_back();
        test_reset_mid_frame();
        test_wide_lsb_first();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: %0d bytes left, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
